// File: rtl/aximm_aib_csr_top.sv
// aximm_aib_csr_top: AVMM CSR front end with AXI-MM burst pattern generator/checker over an internal beat memory.
module aximm_aib_csr_top #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        ms_wr_clk,
  input  logic        i_w_m_wr_rst_n,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wrdata,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_master_readdata,
  output logic        o_master_readdatavalid
);
  localparam logic [31:0] A_WCTL = 32'h5000_1000, A_BASE = 32'h5000_1004, A_STAT = 32'h5000_1008,
                          A_LINK = 32'h5000_100C, A_RCTL = 32'h5000_1010, A_X = 32'h5000_2000,
                          A_Y = 32'h5000_2004, A_Z = 32'h5000_2008;
  typedef enum logic [1:0] {IDLE, PEND, RUN, DONE} st_e;
  function automatic logic [127:0] pat(input logic [31:0] b, input logic [7:0] k);
    logic [31:0] a;
    a = b + {22'd0, k, 2'd0};
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction
  logic [127:0] mem [MEM_DEPTH];
  logic         wren_q, rden_q, rd_pend_q, rvalid_q;
  logic [31:0]  raddr_q, rdata_q, rd_d;
  logic [31:0]  dly_x_q, dly_y_q, dly_z_q, base_q, wctl_q, rctl_q, cnt_q;
  st_e          ws_q, ws_d, rs_q, rs_d;
  logic [7:0]   widx_q, wend_q, ridx_q, rend_q, rk_q;
  logic         rv_q, rlst_q, wdone_q, rdone_q, mism_q, pass_q;
  logic [127:0] rbeat_q, wfirst_q, wlast_q, rfirst_q, rlast_q, wbeat, exp_beat, cap;
  logic [2:0]   gate;
  logic         online, wr_cmd, rd_cmd, wstart, rstart, wr_en, rd_en, miss;
  assign wr_cmd = i_wren & ~wren_q;
  assign rd_cmd = i_rden & ~rden_q;
  assign gate   = {cnt_q >= dly_z_q, cnt_q >= dly_y_q, cnt_q >= dly_x_q};
  assign online = &gate;
  assign wstart = wr_cmd && i_wr_addr == A_WCTL && i_wrdata[2] && (ws_q == IDLE || ws_q == DONE);
  assign rstart = wr_cmd && i_wr_addr == A_RCTL && i_wrdata[2] && (rs_q == IDLE || rs_q == DONE);
  always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
    if (!i_w_m_wr_rst_n) begin
      ws_q <= IDLE;
      rs_q <= IDLE;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
    end
  end
  always_comb begin
    ws_d = IDLE;
    case (ws_q)
      IDLE, DONE: ws_d = wstart ? (online ? RUN : PEND) : IDLE;
      PEND:       ws_d = online ? RUN : PEND;
      RUN:        ws_d = (widx_q == wend_q) ? DONE : RUN;
      default:    ws_d = IDLE;
    endcase
    rs_d = IDLE;
    case (rs_q)
      IDLE, DONE: rs_d = rstart ? (online ? RUN : PEND) : IDLE;
      PEND:       rs_d = online ? RUN : PEND;
      RUN:        rs_d = (ridx_q == rend_q) ? DONE : RUN;
      default:    rs_d = IDLE;
    endcase
  end
  always_comb begin
    wr_en    = ws_q == RUN;
    rd_en    = rs_q == RUN;
    wbeat    = pat(base_q, widx_q);
    exp_beat = pat(base_q, rk_q);
    miss     = rv_q && rbeat_q != exp_beat;
  end
  // Memory contents survive reset; only the engines and flags are cleared.
  always_ff @(posedge ms_wr_clk) begin
    if (wr_en) mem[widx_q] <= wbeat;
    rbeat_q <= mem[ridx_q];
  end
  always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
    if (!i_w_m_wr_rst_n) begin
      widx_q <= '0; wend_q <= '0; wdone_q <= 1'b0; wfirst_q <= '0; wlast_q <= '0;
      ridx_q <= '0; rend_q <= '0; rk_q <= '0; rv_q <= 1'b0; rlst_q <= 1'b0;
      rdone_q <= 1'b0; mism_q <= 1'b0; pass_q <= 1'b0; rfirst_q <= '0; rlast_q <= '0;
    end else begin
      if (wstart) begin
        widx_q <= '0; wend_q <= i_wrdata[11:4] - 8'd1; wdone_q <= 1'b0; wfirst_q <= '0; wlast_q <= '0;
      end else if (wr_en) begin
        widx_q <= widx_q + 8'd1;
        if (widx_q == 8'd0) wfirst_q <= wbeat;
        if (widx_q == wend_q) begin
          wlast_q <= wbeat;
          wdone_q <= 1'b1;
        end
      end
      rv_q   <= rd_en;
      rk_q   <= ridx_q;
      rlst_q <= rd_en && ridx_q == rend_q;
      if (rd_en) ridx_q <= ridx_q + 8'd1;
      // Compare stage runs one cycle behind the memory read.
      if (rv_q) begin
        if (miss) mism_q <= 1'b1;
        if (rk_q == 8'd0) rfirst_q <= rbeat_q;
        if (rlst_q) begin
          rlast_q <= rbeat_q;
          rdone_q <= 1'b1;
          pass_q  <= ~(mism_q | miss);
        end
      end
      if (rstart) begin
        ridx_q <= '0; rend_q <= i_wrdata[11:4] - 8'd1; rv_q <= 1'b0; rlst_q <= 1'b0;
        rdone_q <= 1'b0; mism_q <= 1'b0; pass_q <= 1'b0; rfirst_q <= '0; rlast_q <= '0;
      end
      if (wstart) pass_q <= 1'b0;
    end
  end
  always_comb begin
    cap  = raddr_q[5] ? (raddr_q[4] ? rlast_q : rfirst_q) : (raddr_q[4] ? wlast_q : wfirst_q);
    rd_d = (raddr_q[31:6] == 26'h1400100) ? cap[{raddr_q[3:2], 5'd0} +: 32] : 32'd0;
    case (raddr_q)
      A_X:     rd_d = dly_x_q;
      A_Y:     rd_d = dly_y_q;
      A_Z:     rd_d = dly_z_q;
      A_BASE:  rd_d = base_q;
      A_WCTL:  rd_d = wctl_q;
      A_RCTL:  rd_d = rctl_q;
      A_LINK:  rd_d = {28'd0, online, gate};
      A_STAT:  rd_d = {26'd0, rdone_q, wdone_q, online, online, rdone_q, pass_q};
      default: ;
    endcase
  end
  always_ff @(posedge ms_wr_clk or negedge i_w_m_wr_rst_n) begin
    if (!i_w_m_wr_rst_n) begin
      wren_q <= 1'b0; rden_q <= 1'b0; rd_pend_q <= 1'b0; rvalid_q <= 1'b0;
      raddr_q <= '0; rdata_q <= '0; cnt_q <= '0;
      dly_x_q <= 32'h0C; dly_y_q <= 32'h20; dly_z_q <= 32'h1770;
      base_q <= '0; wctl_q <= '0; rctl_q <= '0;
    end else begin
      wren_q <= i_wren;
      rden_q <= i_rden;
      if (~&cnt_q) cnt_q <= cnt_q + 32'd1;
      if (wr_cmd)
        case (i_wr_addr)
          A_X:     dly_x_q <= i_wrdata;
          A_Y:     dly_y_q <= i_wrdata;
          A_Z:     dly_z_q <= i_wrdata;
          A_BASE:  base_q  <= i_wrdata;
          A_WCTL:  wctl_q  <= i_wrdata & ~32'h4;
          A_RCTL:  rctl_q  <= i_wrdata & ~32'h4;
          default: ;
        endcase
      if (rd_cmd) begin
        rvalid_q <= 1'b0; rd_pend_q <= 1'b1; raddr_q <= i_wr_addr;
      end else if (rd_pend_q) begin
        rdata_q <= rd_d; rvalid_q <= 1'b1; rd_pend_q <= 1'b0;
      end
    end
  end
  assign o_master_readdata      = rdata_q;
  assign o_master_readdatavalid = rvalid_q;
endmodule

// File: tb/tb_aximm_aib_csr_top.sv
// tb_aximm_aib_csr_top: directed CSR-level bench for the AXI-MM pattern generator/checker.
module tb_aximm_aib_csr_top;
  localparam logic [31:0] A_WCTL = 32'h5000_1000, A_BASE = 32'h5000_1004, A_STAT = 32'h5000_1008,
                          A_LINK = 32'h5000_100C, A_RCTL = 32'h5000_1010, A_X = 32'h5000_2000,
                          A_Y = 32'h5000_2004, A_Z = 32'h5000_2008, A_CAP = 32'h5000_4000;
  logic        clk = 1'b0, rst_n = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        rvalid;
  int          tests_run = 0, failed = 0, cyc = 0;
  aximm_aib_csr_top #(.MEM_DEPTH(256)) dut (
    .ms_wr_clk(clk), .i_w_m_wr_rst_n(rst_n), .i_wr_addr(addr), .i_wrdata(wdata),
    .i_wren(wren), .i_rden(rden), .o_master_readdata(rdata), .o_master_readdatavalid(rvalid)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic do_reset;
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic csr_wr(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wren = 1'b0;
    @(negedge clk);
  endtask
  task automatic csr_rd(input logic [31:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    rden = 1'b1; addr = a;
    @(negedge clk);
    rden = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = rvalid;
    end
    d = rdata;
    if (!got) begin
      tests_run++; failed++;
      $display("FAIL rd_valid_timeout addr=%h got valid=0 want 1", a);
      d = 32'hDEAD_BEEF;
    end
  endtask
  task automatic poll(input logic [31:0] a, input logic [31:0] mask, input int max_reads,
                      output logic ok, output logic [31:0] v);
    ok = 1'b0;
    v = '0;
    for (int i = 0; i < max_reads && !ok; i++) begin
      csr_rd(a, v);
      ok = (v & mask) == mask;
    end
  endtask
  task automatic test_reset;
    logic [31:0] v;
    do_reset();
    tests_run++;
    if (rdata !== 32'd0 || rvalid !== 1'b0) begin
      failed++; $display("FAIL reset_outputs got data=%h valid=%b want 0/0", rdata, rvalid);
    end
    csr_rd(A_X, v); tests_run++;
    if (v !== 32'h0C) begin failed++; $display("FAIL reset_x got %h want 0000000c", v); end
    csr_rd(A_Y, v); tests_run++;
    if (v !== 32'h20) begin failed++; $display("FAIL reset_y got %h want 00000020", v); end
    csr_rd(A_Z, v); tests_run++;
    if (v !== 32'h1770) begin failed++; $display("FAIL reset_z got %h want 00001770", v); end
    csr_rd(A_LINK, v); tests_run++;
    if (v[3:2] !== 2'b00) begin failed++; $display("FAIL early_link got %h want bits[3:2]=0", v); end
    csr_rd(A_STAT, v); tests_run++;
    if (v !== 32'd0) begin failed++; $display("FAIL reset_status got %h want 00000000", v); end
  endtask
  task automatic test_link_default;
    logic ok; logic [31:0] v;
    poll(A_LINK, 32'hF, 3000, ok, v);
    tests_run++;
    if (!ok || cyc < 6000 || cyc > 6020) begin
      failed++; $display("FAIL link_default ok=%b link=%h at cycle %0d want F in [6000,6020]", ok, v, cyc);
    end
  endtask
  task automatic test_early_start;
    logic ok; logic [31:0] v;
    do_reset();
    csr_wr(A_BASE, 32'h3000_0000);
    csr_wr(A_WCTL, 32'h0000_0104);
    repeat (100) @(negedge clk);
    csr_rd(A_STAT, v); tests_run++;
    if (v[4] !== 1'b0 || v[2] !== 1'b0) begin failed++; $display("FAIL early_no_done got status %h want bit4=0 bit2=0", v); end
    csr_rd(A_CAP, v); tests_run++;
    if (v !== 32'd0) begin failed++; $display("FAIL early_no_beat got %h want 00000000", v); end
    poll(A_STAT, 32'h10, 3000, ok, v);
    tests_run++;
    if (!ok || cyc < 6016 || cyc > 6040) begin
      failed++; $display("FAIL early_done_time ok=%b at cycle %0d want done in [6016,6040]", ok, cyc);
    end
    csr_rd(A_CAP, v); tests_run++;
    if (v !== 32'h3000_0000) begin failed++; $display("FAIL early_first got %h want 30000000", v); end
    csr_rd(A_CAP + 32'h1C, v); tests_run++;
    if (v !== 32'h3000_003F) begin failed++; $display("FAIL early_last got %h want 3000003f", v); end
  endtask
  task automatic test_link_z;
    logic ok; logic [31:0] v;
    do_reset();
    csr_wr(A_Z, 32'd100);
    csr_rd(A_Z, v); tests_run++;
    if (v !== 32'd100) begin failed++; $display("FAIL z_readback got %h want 00000064", v); end
    poll(A_LINK, 32'hF, 100, ok, v);
    tests_run++;
    if (!ok || cyc < 100 || cyc > 115) begin
      failed++; $display("FAIL link_z ok=%b link=%h at cycle %0d want F in [100,115]", ok, v, cyc);
    end
  endtask
  task automatic test_write_burst;
    logic ok; logic [31:0] v;
    csr_wr(A_BASE, 32'h1000_0000);
    csr_wr(A_WCTL, 32'h0004_1804);
    poll(A_STAT, 32'h10, 200, ok, v);
    tests_run++;
    if (!ok) begin failed++; $display("FAIL wr_done got status %h want bit4=1", v); end
    csr_rd(A_WCTL, v); tests_run++;
    if (v !== 32'h0004_1800) begin failed++; $display("FAIL wctl_readback got %h want 00041800", v); end
    for (int w = 0; w < 4; w++) begin
      csr_rd(A_CAP + 32'(4 * w), v); tests_run++;
      if (v !== 32'h1000_0000 + 32'(w)) begin failed++; $display("FAIL wr_first[%0d] got %h want %h", w, v, 32'h1000_0000 + 32'(w)); end
      csr_rd(A_CAP + 32'h10 + 32'(4 * w), v); tests_run++;
      if (v !== 32'h1000_01FC + 32'(w)) begin failed++; $display("FAIL wr_last[%0d] got %h want %h", w, v, 32'h1000_01FC + 32'(w)); end
    end
  endtask
  task automatic test_read_burst;
    logic ok; logic [31:0] v;
    csr_wr(A_RCTL, 32'h0004_1804);
    poll(A_STAT, 32'h20, 200, ok, v);
    tests_run++;
    if (!ok || v !== 32'h3F) begin failed++; $display("FAIL rd_pass_status ok=%b got %h want 0000003f", ok, v); end
    for (int w = 0; w < 4; w++) begin
      csr_rd(A_CAP + 32'h20 + 32'(4 * w), v); tests_run++;
      if (v !== 32'h1000_0000 + 32'(w)) begin failed++; $display("FAIL rd_first[%0d] got %h want %h", w, v, 32'h1000_0000 + 32'(w)); end
      csr_rd(A_CAP + 32'h30 + 32'(4 * w), v); tests_run++;
      if (v !== 32'h1000_01FC + 32'(w)) begin failed++; $display("FAIL rd_last[%0d] got %h want %h", w, v, 32'h1000_01FC + 32'(w)); end
    end
  endtask
  task automatic test_read_fail;
    logic ok; logic [31:0] v;
    csr_wr(A_BASE, 32'h2000_0000);
    csr_wr(A_RCTL, 32'h0004_1804);
    poll(A_STAT, 32'h20, 200, ok, v);
    tests_run++;
    if (!ok || v[3:0] !== 4'b1110) begin failed++; $display("FAIL rd_fail_status ok=%b got %h want [3:0]=e", ok, v); end
    csr_rd(A_CAP + 32'h20, v); tests_run++;
    if (v !== 32'h1000_0000) begin failed++; $display("FAIL rd_fail_first got %h want 10000000", v); end
  endtask
  task automatic test_held_wren;
    logic ok; logic [31:0] v;
    wren = 1'b1; addr = A_WCTL; wdata = 32'h14;
    @(negedge clk); wdata = 32'h24;
    @(negedge clk); wdata = 32'h34;
    @(negedge clk); wren = 1'b0;
    @(negedge clk);
    poll(A_STAT, 32'h10, 20, ok, v);
    tests_run++;
    if (!ok) begin failed++; $display("FAIL held_done got status %h want bit4=1", v); end
    csr_rd(A_WCTL, v); tests_run++;
    if (v !== 32'h10) begin failed++; $display("FAIL held_single_write got %h want 00000010", v); end
    csr_rd(A_CAP, v); tests_run++;
    if (v !== 32'h2000_0000) begin failed++; $display("FAIL held_first got %h want 20000000", v); end
    csr_rd(A_CAP + 32'h1C, v); tests_run++;
    if (v !== 32'h2000_0003) begin failed++; $display("FAIL held_last got %h want 20000003", v); end
    csr_rd(32'h5000_0000, v); tests_run++;
    if (v !== 32'd0) begin failed++; $display("FAIL unmapped got %h want 00000000", v); end
  endtask
  initial begin
    test_reset();
    test_link_default();
    test_early_start();
    test_link_z();
    test_write_burst();
    test_read_burst();
    test_read_fail();
    test_held_wren();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
